pga_gain_ctrl: RTL
==================

# pga_gain_ctrl

Automatic gain-ranging controller that closes the loop around `pga_stage`. It drives the PGA's 2-bit `gain` and `enable` inputs and consumes its differential outputs `vout_p`/`vout_n`. It measures peak differential magnitude over a sample window and steps gain up or down with hysteresis and a settling interval. It sits between the register block (mode, manual gain, status) and the PGA, upstream of the SAR core.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles ignored after any gain change or enable. Legal range 2..255.
- `WINDOW_LOG2`, default 6: measurement window of 2^WINDOW_LOG2 samples. Legal range 2..12.
- `HI_THRESH`, default 16'h7000: peak magnitude ≥ this steps gain down.
- `LO_THRESH`, default 16'h1800: peak magnitude < this steps gain up. Must satisfy LO_THRESH*2 < HI_THRESH.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: block enable.
- `auto_en`, in, 1: 1 selects auto-ranging, 0 selects manual gain.
- `manual_gain`, in, 2: gain code used when `auto_en`=0.
- `ovr_clr`, in, 1: single-cycle pulse that clears the sticky overrange flag.
- `vout_p`, in, 16: PGA positive output.
- `vout_n`, in, 16: PGA negative output.
- `pga_gain`, out, 2: gain code to the PGA (00=×1 … 11=×4).
- `pga_enable`, out, 1: PGA enable; registered copy of `enable`.
- `peak_mag`, out, 16: peak magnitude of the last completed window.
- `window_done`, out, 1: one-cycle pulse when `peak_mag` updates.
- `range_event`, out, 1: one-cycle pulse when auto mode changes gain.
- `overrange`, out, 1: sticky; set when any measured magnitude = 16'h7FFF.
- `up_count`, out, 8: number of auto gain-up steps (see Configuration).
- `down_count`, out, 8: number of auto gain-down steps (see Configuration).

## Operation
- **Sample magnitude.** diff = `vout_p` − `vout_n`, modulo 2^16, interpreted as signed 16-bit. mag = |diff|, with −32768 saturated to 16'h7FFF.
- **FSM states.** IDLE, SETTLE, MEASURE, DECIDE.
  - IDLE: leave when `enable`=1, go to SETTLE.
  - SETTLE: counts SETTLE_CYCLES cycles, then goes to MEASURE.
  - MEASURE: tracks the running maximum of mag for 2^WINDOW_LOG2 cycles, then goes to DECIDE.
  - DECIDE (1 cycle):
    - Load `peak_mag` and pulse `window_done`.
    - In auto mode, if peak ≥ HI_THRESH and gain > 0: gain−1.
    - Else if peak < LO_THRESH and gain < 3: gain+1.
    - Else no change.
    - On a change: pulse `range_event` and go to SETTLE. Otherwise go to MEASURE with the peak reset.
- **Manual mode.** `pga_gain` = `manual_gain`. Measurement and `peak_mag` still run, but there are no auto steps and `range_event` stays 0.
- **`manual_gain` change while manual.** Gain updates the next cycle and the FSM restarts SETTLE.
- **`auto_en` 1→0.** `pga_gain` loads `manual_gain` the next cycle and the FSM goes to SETTLE. If this coincides with DECIDE, the manual load wins and no `range_event` is produced.
- **`auto_en` 0→1.** Gain is held and the FSM goes to SETTLE.
- **`enable` deasserted in any state.** Next state is IDLE. The in-progress window is discarded, `peak_mag` is held, and `pga_gain` is held.
- **Overrange.** Set by any sample with mag = 16'h7FFF during MEASURE, and cleared by `ovr_clr`. If set and clear occur in the same cycle, set wins.
- **Gain limits.** Gain saturates at 0 and 3; there is no wrap-around.

## Timing
- **Reset values.** `pga_gain`=0, `pga_enable`=0, `peak_mag`=0, `window_done`=0, `range_event`=0, `overrange`=0, counters=0, state=IDLE.
- **Enable path.** `pga_enable` lags `enable` by 1 cycle. SETTLE_CYCLES ≥ 2 covers this 1-cycle delay plus the PGA's 1-cycle register latency.
- **Gain-change cadence.** A gain change is visible on `pga_gain` in the cycle after DECIDE. The period between consecutive auto changes is SETTLE_CYCLES + 2^WINDOW_LOG2 + 1 cycles (69 with defaults).
- **Steady state (no change).** `window_done` repeats every 2^WINDOW_LOG2 + 1 cycles.
- **Sampling.** Inputs are sampled directly; the sample cycle and the magnitude compare occur in the same cycle.

## Configuration
- `PGA_GAIN_CTRL_STATS_EN` defined: `up_count` and `down_count` increment on each auto step, saturate at 255, and clear only on reset.
- Undefined: the counter logic is removed and both ports are driven constant 0.

## Structure
- **Package `pga_pkg`:**
  - `pga_gain_t` (logic [1:0]).
  - `GAIN_MIN`=0, `GAIN_MAX`=3.
  - FSM state enum `pga_gc_state_t`.
  - `PGA_VCM`=16'h8000, `MAG_FS`=16'h7FFF.
- **Sub-module `pga_peak_detect`:** magnitude computation, saturation, and window running-max with a clear input. The FSM, gain register and counters stay in the top level.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-MEASURE → all outputs return to their reset values immediately and state is IDLE.
- **Step up to maximum.** Auto mode with `vout_p`=16'h8100, `vout_n`=16'h7F00 (mag 16'h0200) → gain goes 0→1→2→3 at 69-cycle intervals, with 3 `range_event` pulses. Gain then stays 3 and `up_count`=3 when stats are enabled.
- **Overrange and step down.** Gain 3 with `vout_p`=16'hC000, `vout_n`=16'h4000 (diff −32768) → mag 16'h7FFF, `overrange`=1, gain 3→2. Then `ovr_clr` → `overrange`=0.
- **Mid-band hold.** mag 16'h4000 → gain unchanged over 3 windows, with `window_done` every 65 cycles and `peak_mag`=16'h4000.
- **Enable drop.** Drop `enable` at cycle 20 of MEASURE → IDLE next cycle; `peak_mag` and gain are held. Re-enable → SETTLE restarts, and the first `window_done` arrives after 4 + 64 + 1 cycles.
- **`auto_en` fall in DECIDE.** `auto_en` falls in the DECIDE cycle with `manual_gain`=1 and a step-up pending → `pga_gain`=1 and no `range_event`.

Source files
------------

// File: rtl/pga_pkg.sv
// Shared types and constants for the PGA gain-ranging controller.
//   pga_gain_t      : 2-bit PGA gain code (00 = x1 ... 11 = x4)
//   GAIN_MIN/MAX    : gain saturation limits
//   pga_gc_state_t  : controller FSM state
//   PGA_VCM         : PGA output common-mode code
//   MAG_FS          : full-scale (saturated) magnitude
package pga_pkg;

  typedef logic [1:0] pga_gain_t;

  localparam pga_gain_t GAIN_MIN = 2'd0;
  localparam pga_gain_t GAIN_MAX = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StMeasure,
    StDecide
  } pga_gc_state_t;

  localparam logic [15:0] PGA_VCM = 16'h8000;
  localparam logic [15:0] MAG_FS  = 16'h7FFF;

endpackage

// File: rtl/pga_gain_ctrl_if.sv
// Signal bundle between the register block / PGA side (master) and the gain controller (slave).
//   Master drives : enable, auto_en, manual_gain, ovr_clr, vout_p, vout_n
//   Slave drives  : pga_gain, pga_enable, peak_mag, window_done, range_event, overrange,
//                   up_count, down_count
interface pga_gain_ctrl_if;

  logic                enable;
  logic                auto_en;
  pga_pkg::pga_gain_t  manual_gain;
  logic                ovr_clr;
  logic [15:0]         vout_p;
  logic [15:0]         vout_n;
  pga_pkg::pga_gain_t  pga_gain;
  logic                pga_enable;
  logic [15:0]         peak_mag;
  logic                window_done;
  logic                range_event;
  logic                overrange;
  logic [7:0]          up_count;
  logic [7:0]          down_count;

  modport master (
    output enable, auto_en, manual_gain, ovr_clr, vout_p, vout_n,
    input  pga_gain, pga_enable, peak_mag, window_done, range_event, overrange,
           up_count, down_count
  );

  modport slave (
    input  enable, auto_en, manual_gain, ovr_clr, vout_p, vout_n,
    output pga_gain, pga_enable, peak_mag, window_done, range_event, overrange,
           up_count, down_count
  );

endinterface

// File: rtl/pga_peak_detect.sv
// Differential magnitude and window running-maximum.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_vout_p/n   : PGA differential outputs
//   i_sample     : fold the current magnitude into the running max
//   i_clr        : clear the running max (takes priority over i_sample)
//   o_mag        : combinational magnitude of the current sample
//   o_peak       : running max of the samples taken since the last clear
module pga_peak_detect
  import pga_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] i_vout_p,
  input  logic [15:0] i_vout_n,
  input  logic        i_sample,
  input  logic        i_clr,
  output logic [15:0] o_mag,
  output logic [15:0] o_peak
);

  logic [15:0] w_diff;
  logic [15:0] w_mag;
  logic [15:0] r_peak_q;

  assign w_diff = i_vout_p - i_vout_n;

  // |diff| of a signed 16-bit value; -32768 has no positive twin so it saturates.
  always_comb begin
    w_mag = w_diff;
    if (w_diff == 16'h8000) begin
      w_mag = MAG_FS;
    end else if (w_diff[15]) begin
      w_mag = ~w_diff + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_peak_q <= '0;
    end else if (i_clr) begin
      r_peak_q <= '0;
    end else if (i_sample && (w_mag > r_peak_q)) begin
      r_peak_q <= w_mag;
    end
  end

  assign o_mag  = w_mag;
  assign o_peak = r_peak_q;

endmodule

// File: rtl/pga_gain_ctrl.sv
// Automatic gain-ranging controller around the PGA. Measures the peak differential magnitude
// over a window of 2^WINDOW_LOG2 samples and steps the gain with hysteresis, waiting
// SETTLE_CYCLES after every gain change or enable before measuring again.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : enable/auto_en/manual_gain/ovr_clr/vout_p/vout_n in; pga_gain, pga_enable,
//                  peak_mag, window_done, range_event, overrange, up_count, down_count out
// Build option: define PGA_GAIN_CTRL_STATS_EN to keep the saturating up/down step counters;
// otherwise up_count and down_count are tied to zero.
module pga_gain_ctrl
  import pga_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned WINDOW_LOG2   = 6,
  parameter logic [15:0] HI_THRESH     = 16'h7000,
  parameter logic [15:0] LO_THRESH     = 16'h1800
) (
  input  logic            clk,
  input  logic            reset_n,
  pga_gain_ctrl_if.slave  bus
);

  localparam logic [11:0] SettleLast = 12'(SETTLE_CYCLES - 1);
  localparam logic [11:0] WinLast    = 12'((1 << WINDOW_LOG2) - 1);

  pga_gc_state_t r_state_q, r_state_d;
  logic [11:0]   r_cnt_q, r_cnt_d;
  pga_gain_t     r_gain_q, r_gain_d;
  logic [15:0]   r_peak_mag_q, r_peak_mag_d;
  logic          r_window_done_q, r_window_done_d;
  logic          r_range_event_q, r_range_event_d;
  logic          r_ovr_q, r_ovr_d;
  logic          r_auto_q;
  logic          r_pga_enable_q;
  logic          w_step_up, w_step_dn;
  logic          w_sample;
  logic [15:0]   w_mag;
  logic [15:0]   w_peak;

  assign w_sample = (r_state_q == StMeasure);

  // Peak is cleared in every non-MEASURE cycle, so a window abandoned for any reason
  // (enable drop, mode change, gain step) never leaks into the next one.
  pga_peak_detect u_peak_detect (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_vout_p (bus.vout_p),
    .i_vout_n (bus.vout_n),
    .i_sample (w_sample),
    .i_clr    (!w_sample),
    .o_mag    (w_mag),
    .o_peak   (w_peak)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q       <= StIdle;
      r_cnt_q         <= '0;
      r_gain_q        <= GAIN_MIN;
      r_peak_mag_q    <= '0;
      r_window_done_q <= 1'b0;
      r_range_event_q <= 1'b0;
      r_ovr_q         <= 1'b0;
      r_auto_q        <= 1'b0;
      r_pga_enable_q  <= 1'b0;
    end else begin
      r_state_q       <= r_state_d;
      r_cnt_q         <= r_cnt_d;
      r_gain_q        <= r_gain_d;
      r_peak_mag_q    <= r_peak_mag_d;
      r_window_done_q <= r_window_done_d;
      r_range_event_q <= r_range_event_d;
      r_ovr_q         <= r_ovr_d;
      r_auto_q        <= bus.auto_en;
      r_pga_enable_q  <= bus.enable;
    end
  end

  always_comb begin
    r_state_d       = r_state_q;
    r_cnt_d         = r_cnt_q;
    r_gain_d        = r_gain_q;
    r_peak_mag_d    = r_peak_mag_q;
    r_window_done_d = 1'b0;
    w_step_up       = 1'b0;
    w_step_dn       = 1'b0;

    if (!bus.enable) begin
      // Gain and last peak are held while disabled.
      r_state_d = StIdle;
      r_cnt_d   = '0;
    end else begin
      unique case (r_state_q)
        StIdle: begin
          r_state_d = StSettle;
          r_cnt_d   = '0;
        end
        StSettle: begin
          if (r_cnt_q == SettleLast) begin
            r_state_d = StMeasure;
            r_cnt_d   = '0;
          end else begin
            r_cnt_d = r_cnt_q + 12'd1;
          end
        end
        StMeasure: begin
          if (r_cnt_q == WinLast) begin
            r_state_d = StDecide;
            r_cnt_d   = '0;
          end else begin
            r_cnt_d = r_cnt_q + 12'd1;
          end
        end
        StDecide: begin
          r_peak_mag_d    = w_peak;
          r_window_done_d = 1'b1;
          // A mode change in this very cycle suppresses the auto decision.
          if (bus.auto_en && r_auto_q) begin
            if ((w_peak >= HI_THRESH) && (r_gain_q != GAIN_MIN)) begin
              w_step_dn = 1'b1;
            end else if ((w_peak < LO_THRESH) && (r_gain_q != GAIN_MAX)) begin
              w_step_up = 1'b1;
            end
          end
          r_cnt_d = '0;
          if (w_step_up) begin
            r_gain_d  = r_gain_q + 2'd1;
            r_state_d = StSettle;
          end else if (w_step_dn) begin
            r_gain_d  = r_gain_q - 2'd1;
            r_state_d = StSettle;
          end else begin
            r_state_d = StMeasure;
          end
        end
        default: r_state_d = StIdle;
      endcase

      // Mode/manual-gain events override the normal sequence and restart settling.
      if (!bus.auto_en && (r_auto_q || (bus.manual_gain != r_gain_q))) begin
        r_gain_d  = bus.manual_gain;
        r_state_d = StSettle;
        r_cnt_d   = '0;
        w_step_up = 1'b0;
        w_step_dn = 1'b0;
      end else if (bus.auto_en && !r_auto_q) begin
        r_state_d = StSettle;
        r_cnt_d   = '0;
      end
    end

    r_range_event_d = w_step_up | w_step_dn;

    // Set wins over a simultaneous clear.
    if (w_sample && (w_mag == MAG_FS)) begin
      r_ovr_d = 1'b1;
    end else if (bus.ovr_clr) begin
      r_ovr_d = 1'b0;
    end else begin
      r_ovr_d = r_ovr_q;
    end
  end

`ifdef PGA_GAIN_CTRL_STATS_EN
  logic [7:0] r_up_cnt_q, r_dn_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_up_cnt_q <= '0;
      r_dn_cnt_q <= '0;
    end else begin
      if (w_step_up && (r_up_cnt_q != 8'hFF)) begin
        r_up_cnt_q <= r_up_cnt_q + 8'd1;
      end
      if (w_step_dn && (r_dn_cnt_q != 8'hFF)) begin
        r_dn_cnt_q <= r_dn_cnt_q + 8'd1;
      end
    end
  end

  assign bus.up_count   = r_up_cnt_q;
  assign bus.down_count = r_dn_cnt_q;
`else
  assign bus.up_count   = 8'd0;
  assign bus.down_count = 8'd0;
`endif

  assign bus.pga_gain    = r_gain_q;
  assign bus.pga_enable  = r_pga_enable_q;
  assign bus.peak_mag    = r_peak_mag_q;
  assign bus.window_done = r_window_done_q;
  assign bus.range_event = r_range_event_q;
  assign bus.overrange   = r_ovr_q;

endmodule
